// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller.
//   DATA_W              : CPU data path width (address / write data)
//   ENABLE_N, DISABLE_N : levels of the active-low CPU reset (held / released)
//   state_t             : run controller state encoding
//   is_done_write()     : recognises the end-of-run store
package run_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TMO  = 3'd4
  } state_t;

  // A store ends the run only when it is a real write to the exact address;
  // all DATA_W bits take part in the compare.
  function automatic logic is_done_write(input logic              we,
                                         input logic [DATA_W-1:0] addr,
                                         input logic [DATA_W-1:0] target);
    return we && (addr == target);
  endfunction

endpackage

// File: rtl/run_cnt.sv
// 32-bit up counter with synchronous clear and count enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, wins over en
//   en    : increment by one this edge
//   q     : current count
module run_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 32'd0;
    end else if (clr) begin
      q <= 32'd0;
    end else if (en) begin
      q <= q + 32'd1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the CPU in reset for HOLD_CYC cycles after start,
// releases it, counts run cycles and ends the run on a store to DONE_ADDR
// (done) or after TIMEOUT run cycles (timeout). All outputs are registered.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   start     : begin a run (honoured in IDLE, DONE and TMO)
//   memwrite  : CPU data-memory write enable
//   daddr     : CPU data address
//   wdata     : CPU data-memory write data
//   cpu_rst_n : active-low reset to the CPU
//   running   : high while the CPU runs
//   done      : sticky, run ended by the done store
//   timeout   : sticky, run ended by the cycle limit
//   cycles    : number of run cycles counted
//   result    : write data captured by the done store
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned       HOLD_CYC  = 2,
  parameter logic [DATA_W-1:0] DONE_ADDR = 32'h00000050,
  parameter int unsigned       TIMEOUT   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              cpu_rst_n,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycles,
  output logic [DATA_W-1:0] result
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [32:0] TMO_LIMIT = 33'(TIMEOUT);

  state_t            state, state_nxt;
  logic [31:0]       cnt_q;
  logic              cnt_clr, cnt_en;
  logic [31:0]       cnt_inc;
  logic              at_limit, done_evt;
  logic              cpu_rst_n_d, running_d, done_d, timeout_d;
  logic [31:0]       cycles_d;
  logic [DATA_W-1:0] result_d;

  // One counter serves both phases: it times the reset hold, is cleared on
  // the edge that enters RUN, and from then on equals the run cycle count.
  run_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt_q)
  );

  assign cnt_inc  = cnt_q + 32'd1;
  // 33-bit compare so a limit of 2^32-1 cannot wrap.
  assign at_limit = ({1'b0, cnt_q} + 33'd1) == TMO_LIMIT;
  assign done_evt = is_done_write(memwrite, daddr, DONE_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cpu_rst_n <= ENABLE_N;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycles    <= 32'd0;
      result    <= '0;
    end else begin
      state     <= state_nxt;
      cpu_rst_n <= cpu_rst_n_d;
      running   <= running_d;
      done      <= done_d;
      timeout   <= timeout_d;
      cycles    <= cycles_d;
      result    <= result_d;
    end
  end

  // Next-state and next-output values. The CPU stays in reset unless the
  // next state is RUN, so only RUN paths release it.
  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    cpu_rst_n_d = ENABLE_N;
    running_d   = 1'b0;
    done_d      = done;
    timeout_d   = timeout;
    cycles_d    = cycles;
    result_d    = result;

    case (state)
      S_IDLE, S_DONE, S_TMO: begin
        if (start) begin
          state_nxt = S_HOLD;
          cnt_clr   = 1'b1;
          cycles_d  = 32'd0;
          result_d  = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end

      S_HOLD: begin
        cnt_en = 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_nxt   = S_RUN;
          cnt_clr     = 1'b1;
          cpu_rst_n_d = DISABLE_N;
          running_d   = 1'b1;
        end
      end

      S_RUN: begin
        // The terminating cycle is itself counted.
        cnt_en   = 1'b1;
        cycles_d = cnt_inc;
        if (done_evt) begin
          state_nxt = S_DONE;
          done_d    = 1'b1;
          result_d  = wdata;
        end else if (at_limit) begin
          state_nxt = S_TMO;
          timeout_d = 1'b1;
        end else begin
          cpu_rst_n_d = DISABLE_N;
          running_d   = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int unsigned HOLD = 2;
  localparam int unsigned TMO  = 20;
  localparam logic [31:0] DADR = 32'h00000050;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, memwrite;
  logic [31:0] daddr, wdata;
  logic        cpu_rst_n, running, done, timeout;
  logic [31:0] cycles, result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_ctrl #(.HOLD_CYC(HOLD), .DONE_ADDR(DADR), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .memwrite  (memwrite),
    .daddr     (daddr),
    .wdata     (wdata),
    .cpu_rst_n (cpu_rst_n),
    .running   (running),
    .done      (done),
    .timeout   (timeout),
    .cycles    (cycles),
    .result    (result)
  );

  // Reference model: a run is a phase plus a few counters.
  localparam int P_IDLE = 0, P_HOLD = 1, P_RUN = 2, P_END = 3;
  int          m_phase;
  int          m_hold_left;
  logic [31:0] m_cycles, m_result;
  logic        m_done, m_tmo;

  task automatic model_reset();
    m_phase = P_IDLE; m_hold_left = 0;
    m_cycles = 0; m_result = 0; m_done = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      P_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) m_phase = P_RUN;
      end
      P_RUN: begin
        m_cycles++;
        if (memwrite && daddr == DADR) begin
          m_done = 1; m_result = wdata; m_phase = P_END;
        end else if (m_cycles == TMO) begin
          m_tmo = 1; m_phase = P_END;
        end
      end
      default: begin
        if (start) begin
          m_phase = P_HOLD; m_hold_left = HOLD;
          m_cycles = 0; m_result = 0; m_done = 0; m_tmo = 0;
        end
      end
    endcase
  endtask

  task automatic check(input string nm, input logic e_crn, input logic e_run,
                       input logic e_dn, input logic e_to,
                       input logic [31:0] e_cyc, input logic [31:0] e_res);
    n_vec++;
    if (cpu_rst_n !== e_crn || running !== e_run || done !== e_dn ||
        timeout !== e_to || cycles !== e_cyc || result !== e_res) begin
      n_err++;
      $display("FAIL %s: got crn=%b run=%b done=%b tmo=%b cyc=%0d res=%h, want crn=%b run=%b done=%b tmo=%b cyc=%0d res=%h",
               nm, cpu_rst_n, running, done, timeout, cycles, result,
               e_crn, e_run, e_dn, e_to, e_cyc, e_res);
    end
  endtask

  task automatic check_model(input string nm);
    logic r;
    r = (m_phase == P_RUN);
    check(nm, r, r, m_done, m_tmo, m_cycles, m_result);
  endtask

  task automatic drive(input logic s, input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    start = s; memwrite = we; daddr = a; wdata = d;
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        st, we;
    logic [31:0] addr, wd;
    logic        crn, run, dn, to;
    logic [31:0] cyc, res;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic we,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic crn, input logic run,
                              input logic dn, input logic to,
                              input logic [31:0] cyc, input logic [31:0] res);
    vec_t v;
    v.st = st; v.we = we; v.addr = addr; v.wd = wd;
    v.crn = crn; v.run = run; v.dn = dn; v.to = to; v.cyc = cyc; v.res = res;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();

    tbl[0]  = mk(0, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0);   // idle after reset
    tbl[1]  = mk(1, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0);   // enter hold
    tbl[2]  = mk(1, 1, 32'h50, 32'h9, 0, 0, 0, 0, 0, 0);   // hold 2nd cycle, inputs ignored
    tbl[3]  = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 0, 0);   // released into run
    tbl[4]  = mk(0, 1, 32'h54, 32'h3, 1, 1, 0, 0, 1, 0);   // write elsewhere
    tbl[5]  = mk(0, 0, 32'h50, 32'h5, 1, 1, 0, 0, 2, 0);   // done addr without we
    tbl[6]  = mk(1, 0, 32'h00, 32'h0, 1, 1, 0, 0, 3, 0);   // start in run ignored
    tbl[7]  = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 4, 0);
    tbl[8]  = mk(0, 1, 32'h8000_0050, 32'h1, 1, 1, 0, 0, 5, 0); // upper bits differ
    tbl[9]  = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 6, 0);
    tbl[10] = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 7, 0);
    tbl[11] = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 8, 0);
    tbl[12] = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 9, 0);
    tbl[13] = mk(0, 1, 32'h50, 32'h7, 0, 0, 1, 0, 10, 7);  // done write
    tbl[14] = mk(0, 1, 32'h50, 32'h9, 0, 0, 1, 0, 10, 7);  // frozen in done
    tbl[15] = mk(1, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0);   // restart from done
    tbl[16] = mk(0, 0, 32'h00, 32'h0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 32'h00, 32'h0, 1, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 check("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].st, tbl[i].we, tbl[i].addr, tbl[i].wd);
      step();
      check($sformatf("vec%0d", i), tbl[i].crn, tbl[i].run, tbl[i].dn,
            tbl[i].to, tbl[i].cyc, tbl[i].res);
    end

    // Timeout with no done write, from run entry (cycles=0).
    drive(0, 0, 0, 0);
    repeat (19) step();
    check("pre_timeout", 1, 1, 0, 0, 19, 0);
    step();
    check("timeout", 0, 0, 0, 1, 20, 0);
    step();
    check("tmo_sticky", 0, 0, 0, 1, 20, 0);

    // Restart from TMO; done write on the limit cycle wins.
    drive(1, 0, 0, 0);
    step();
    check("restart_tmo", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    step(); step();
    check("run_again", 1, 1, 0, 0, 0, 0);
    repeat (19) step();
    drive(0, 1, 32'h50, 32'hCAFE_F00D);
    step();
    check("done_beats_tmo", 0, 0, 1, 0, 20, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of a run.
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (2 + 5) step();
    check("mid_run", 1, 1, 0, 0, 5, 0);
    async_reset_pulse();
    repeat (3) step();
    check("idle_after_reset", 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0);
    step();
    check("start_after_reset", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0, 1: a = DADR;
        2:    a = 32'h54;
        3:    a = DADR | (32'h1 << $urandom_range(7, 31));
        default: a = $urandom;
      endcase
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), a, $urandom);
      step();
      check_model($sformatf("rand%0d", c));
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
